// File: rtl/wvb_reader.sv
`default_nettype none
// ============================================================================
// Module   : wvb_reader
// Brief    : Read-side engine of the mDOM waveform buffer. Pops one event
//            header, streams the event's words (start..stop, with address
//            wrap) from the buffer RAM onto a valid/ready port through a
//            2-entry output FIFO, then pulses wvb_rddone together with
//            hdr_rdreq.
//            Optional macro WVB_READER_HDR_WORD_EN: emit a leading
//            {zero-pad, evt_len} word (HDRW state) before the waveform words.
// Revision : 1.0 - initial release
// ============================================================================
module wvb_reader #(
    parameter int P_ADR_WIDTH  = 12,
    parameter int P_DATA_WIDTH = 22
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    hdr_empty,
    input  logic [P_ADR_WIDTH-1:0]  hdr_start_addr,
    input  logic [P_ADR_WIDTH-1:0]  hdr_stop_addr,
    output logic                    hdr_rdreq,
    output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
    input  logic [P_DATA_WIDTH-1:0] wvb_rd_data,
    output logic                    wvb_rddone,
    output logic [P_DATA_WIDTH-1:0] dout_data,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    dout_sof,
    output logic                    dout_eof,
    output logic                    busy,
    output logic [P_ADR_WIDTH:0]    evt_len
);

    localparam int c_CNT_W = P_ADR_WIDTH + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STREAM = 3'd2,
        S_DONE   = 3'd3,
        S_GAP    = 3'd4
`ifdef WVB_READER_HDR_WORD_EN
        , S_HDRW = 3'd5
`endif
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [P_ADR_WIDTH-1:0]    r_rd_ptr;
    logic [P_ADR_WIDTH-1:0]    r_addr_hold;
    logic [c_CNT_W-1:0]        r_evt_len;
    logic [c_CNT_W-1:0]        r_issue_cnt;
    logic [c_CNT_W-1:0]        r_accept_cnt;
    logic                      r_inflight;
    logic [P_DATA_WIDTH-1:0]   r_fifo_data [2];
    logic                      r_wr_idx;
    logic                      r_rd_idx;
    logic [1:0]                r_fifo_cnt;
    logic [c_CNT_W-1:0]        w_len;
    logic                      w_fetch;
    logic                      w_pop;
    logic                      w_issue;
    logic [1:0]                w_occ;

    // Event length; subtraction wraps at the address width so stop==start-1 means a full buffer
    assign w_len       = {1'b0, hdr_stop_addr - hdr_start_addr} + c_CNT_ONE;
    assign wvb_rd_addr = w_issue ? r_rd_ptr : r_addr_hold;
    assign busy        = (r_state != S_IDLE);
    assign evt_len     = r_evt_len;

    // Next-state, output port and read-issue decode
    always_comb begin
        w_next     = r_state;
        hdr_rdreq  = 1'b0;
        wvb_rddone = 1'b0;
        dout_valid = 1'b0;
        dout_data  = '0;
        dout_sof   = 1'b0;
        dout_eof   = 1'b0;
        w_fetch    = 1'b0;
        w_pop      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!hdr_empty) begin
                    w_next = S_LOAD;
                end
            end
`ifdef WVB_READER_HDR_WORD_EN
            S_LOAD: w_next = S_HDRW;
            S_HDRW: begin
                // Prefetch waveform words while the length word waits for acceptance
                w_fetch    = 1'b1;
                dout_valid = 1'b1;
                dout_data  = P_DATA_WIDTH'(r_evt_len);
                dout_sof   = 1'b1;
                if (dout_ready) begin
                    w_next = S_STREAM;
                end
            end
`else
            S_LOAD: w_next = S_STREAM;
`endif
            S_STREAM: begin
                w_fetch    = 1'b1;
                dout_valid = (r_fifo_cnt != 2'd0);
                if (dout_valid) begin
                    dout_data = r_fifo_data[r_rd_idx];
                    dout_eof  = (r_accept_cnt == c_CNT_ONE);
`ifndef WVB_READER_HDR_WORD_EN
                    dout_sof  = (r_accept_cnt == r_evt_len);
`endif
                end
                w_pop = dout_valid && dout_ready;
                if (w_pop && (r_accept_cnt == c_CNT_ONE)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                // Overflow controller samples stop_addr from the FIFO head on rddone, so pop together
                wvb_rddone = 1'b1;
                hdr_rdreq  = 1'b1;
                w_next     = S_GAP;
            end
            S_GAP:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        // Occupancy after this cycle's pop; keeps at most two words owed to the FIFO
        w_occ   = r_fifo_cnt - {1'b0, w_pop} + {1'b0, r_inflight};
        w_issue = w_fetch && (r_issue_cnt != '0) && (w_occ < 2'd2);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Header latch, read pointer, counters and the 2-entry output FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr       <= '0;
            r_addr_hold    <= '0;
            r_evt_len      <= '0;
            r_issue_cnt    <= '0;
            r_accept_cnt   <= '0;
            r_inflight     <= 1'b0;
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_wr_idx       <= 1'b0;
            r_rd_idx       <= 1'b0;
            r_fifo_cnt     <= 2'd0;
        end else if (r_state == S_LOAD) begin
            r_rd_ptr     <= hdr_start_addr;
            r_evt_len    <= w_len;
            r_issue_cnt  <= w_len;
            r_accept_cnt <= w_len;
            r_inflight   <= 1'b0;
            r_wr_idx     <= 1'b0;
            r_rd_idx     <= 1'b0;
            r_fifo_cnt   <= 2'd0;
        end else begin
            if (w_issue) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_addr_hold <= r_rd_ptr;
                r_issue_cnt <= r_issue_cnt - c_CNT_ONE;
            end
            r_inflight <= w_issue;
            if (r_inflight) begin
                r_fifo_data[r_wr_idx] <= wvb_rd_data;
                r_wr_idx              <= ~r_wr_idx;
            end
            if (w_pop) begin
                r_rd_idx     <= ~r_rd_idx;
                r_accept_cnt <= r_accept_cnt - c_CNT_ONE;
            end
            r_fifo_cnt <= r_fifo_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

endmodule
`default_nettype wire
